// File: rtl/regbank_wr_arbiter.sv
// regbank_wr_arbiter: a bank of NREGS x WIDTH registers with one write port.
// The write port is shared among NREQ requesters by a round-robin arbiter
// driving a two-state IDLE/WRITE FSM. All registers are always visible on q.
// Optional feature macro: REGBANK_LOCK_EN. When it is defined, a granted
// requester holding lock and req keeps the write port for a burst of up to
// 8 consecutive write cycles. When it is undefined, the lock input is ignored.
module regbank_wr_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned NREGS = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*AW-1:0]     waddr,
    input  logic [NREQ*WIDTH-1:0]  wdata,
    input  logic [NREQ-1:0]        lock,
    output logic [NREQ-1:0]        gnt,
    output logic                   err,
    output logic                   busy,
    output logic [NREGS*WIDTH-1:0] q
);

    localparam int unsigned PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW        = 4;
    localparam int unsigned BURST_MAX = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    // State registers
    state_t            state_q;
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     w_q;
    logic [NREQ-1:0]   gnt_q;
    logic              err_q;
    logic              busy_q;
    logic [WIDTH-1:0]  regs_q [NREGS];

    // Combinational helpers
    logic [AW-1:0]     waddr_a [NREQ];
    logic [WIDTH-1:0]  wdata_a [NREQ];
    logic [PW-1:0]     win_idx_d;
    logic [PW-1:0]     ptr_adv_d;
    logic [AW-1:0]     cur_addr_c;
    logic [WIDTH-1:0]  cur_data_c;
    logic              cur_ok_c;
    logic              win_ok_c;
    logic              hold_d;

    // True when an address selects an existing register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < NREGS);
    endfunction

    // First set request bit at or above p, wrapping modulo NREQ.
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [PW-1:0]   p);
        logic [PW-1:0] sel;
        logic [PW-1:0] idx;
        logic          found;
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = PW'((32'(p) + k) % NREQ);
            if (!found && r[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // Split the flat request buses into per-requester slices.
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign waddr_a[i] = waddr[i*AW +: AW];
        assign wdata_a[i] = wdata[i*WIDTH +: WIDTH];
    end

    // Expose every register on the flat read bus.
    for (genvar k = 0; k < NREGS; k++) begin : g_pack
        assign q[k*WIDTH +: WIDTH] = regs_q[k];
    end

    // Arbitration result and the live write slice of the current winner.
    always_comb begin
        win_idx_d  = rr_pick(req, ptr_q);
        win_ok_c   = addr_ok(waddr_a[win_idx_d]);
        ptr_adv_d  = (w_q == PW'(NREQ - 1)) ? '0 : (w_q + PW'(1));
        cur_addr_c = waddr_a[w_q];
        cur_data_c = wdata_a[w_q];
        cur_ok_c   = addr_ok(cur_addr_c);
    end

`ifdef REGBANK_LOCK_EN
    // Number of WRITE cycles spent in the current burst, starting at 1.
    logic [CW-1:0] burst_q;

    // Stay in WRITE while the winner keeps lock and req and the cap is not hit.
    always_comb begin
        hold_d = lock[w_q] && req[w_q] && (burst_q != CW'(BURST_MAX));
    end
`else
    logic unused_lock;

    // Bursts are not supported in this build: every WRITE lasts one cycle.
    assign unused_lock = ^lock;
    assign hold_d      = 1'b0;
`endif

    // Arbiter FSM with registered grant, error and busy flags.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            w_q     <= '0;
            gnt_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef REGBANK_LOCK_EN
            burst_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q <= WRITE;
                        w_q     <= win_idx_d;
                        gnt_q   <= NREQ'(1) << win_idx_d;
                        busy_q  <= 1'b1;
                        err_q   <= !win_ok_c;
`ifdef REGBANK_LOCK_EN
                        burst_q <= CW'(1);
`endif
                    end
                end
                WRITE: begin
                    if (hold_d) begin
                        // Burst continues with the same winner; ptr stays put.
                        err_q   <= !cur_ok_c;
`ifdef REGBANK_LOCK_EN
                        burst_q <= burst_q + CW'(1);
`endif
                    end else begin
                        state_q <= IDLE;
                        ptr_q   <= ptr_adv_d;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    // Register bank: reset clears everything and overrides a pending write.
    always_ff @(posedge clk) begin
        if (res) begin
            for (int unsigned k = 0; k < NREGS; k++) begin
                regs_q[k] <= '0;
            end
        end else if ((state_q == WRITE) && cur_ok_c) begin
            regs_q[cur_addr_c] <= cur_data_c;
        end
    end

    assign gnt  = gnt_q;
    assign err  = err_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Scoreboard bench for regbank_wr_arbiter. The stimulus process runs a
// transaction-level reference model and queues the grant expected at each
// edge; a separate monitor compares what the DUT presents.
// The bank is sized to 5 registers so that 3-bit addresses 5..7 are out of range.
module tb_regbank_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int NREGS = 5;
    localparam int WIDTH = 8;
    localparam int AW    = 3;
`ifdef REGBANK_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   res = 1'b1;
    logic [NREQ-1:0]        req = '0;
    logic [NREQ-1:0]        lock = '0;
    logic [NREQ*AW-1:0]     waddr = '0;
    logic [NREQ*WIDTH-1:0]  wdata = '0;
    logic [NREQ-1:0]        gnt;
    logic                   err;
    logic                   busy;
    logic [NREGS*WIDTH-1:0] q;

    regbank_wr_arbiter #(
        .NREQ  (NREQ),
        .NREGS (NREGS),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) dut (
        .clk   (clk),
        .res   (res),
        .req   (req),
        .waddr (waddr),
        .wdata (wdata),
        .lock  (lock),
        .gnt   (gnt),
        .err   (err),
        .busy  (busy),
        .q     (q)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        int w;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    int   gnt_log[$];
    int   edge_cnt = 0;
    bit   mon_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic [WIDTH-1:0] m_bank [NREGS];
    int               m_ptr = 0;
    int               m_w = 0;
    int               m_burst = 0;
    bit               m_busy = 1'b0;
    bit               m_done [NREQ];

    // Per-requester drive values
    logic [AW-1:0]    a_drv [NREQ];
    logic [WIDTH-1:0] d_drv [NREQ];
    bit               pend  [NREQ];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitor: one set of comparisons per clock, 1 ns after the edge.
    always @(posedge clk) begin : mon
        logic [NREQ-1:0]        eg;
        bit                     ee;
        bit                     eb;
        exp_t                   e;
        logic [NREGS*WIDTH-1:0] qe;
        #1;
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].n == edge_cnt) begin
                e  = exp_q.pop_front();
                eg = NREQ'(1) << e.w;
                ee = e.err;
                eb = 1'b1;
            end else begin
                eg = '0;
                ee = 1'b0;
                eb = 1'b0;
            end
            for (int k = 0; k < NREQ; k++) if (gnt[k]) gnt_log.push_back(k);
            for (int k = 0; k < NREGS; k++) qe[k*WIDTH +: WIDTH] = m_bank[k];
            checks++;
            if (gnt !== eg) begin
                errors++;
                $display("FAIL gnt edge=%0d got %b want %b", edge_cnt, gnt, eg);
            end
            checks++;
            if (err !== ee) begin
                errors++;
                $display("FAIL err edge=%0d got %b want %b", edge_cnt, err, ee);
            end
            checks++;
            if (busy !== eb) begin
                errors++;
                $display("FAIL busy edge=%0d got %b want %b", edge_cnt, busy, eb);
            end
            checks++;
            if (q !== qe) begin
                errors++;
                $display("FAIL q edge=%0d got %h want %h", edge_cnt, q, qe);
            end
        end
    end

    // What the bank and the arbiter do at edge n, from the behavioural rules.
    task automatic model_edge(input int n, input bit r,
                              input logic [NREQ-1:0] rq, input logic [NREQ-1:0] lk);
        int   a;
        int   idx;
        exp_t e;
        if (r) begin
            for (int k = 0; k < NREGS; k++) m_bank[k] = '0;
            m_busy = 1'b0;
            m_ptr  = 0;
            m_w    = 0;
            return;
        end
        if (m_busy) begin
            a = int'(a_drv[m_w]);
            if (a < NREGS) m_bank[a] = d_drv[m_w];
            if (LOCK_EN && lk[m_w] && rq[m_w] && m_burst < 8) begin
                m_burst++;
                e.n = n; e.w = m_w; e.err = (a >= NREGS);
                exp_q.push_back(e);
            end else begin
                m_busy       = 1'b0;
                m_done[m_w]  = 1'b1;
                m_ptr        = (m_w + 1) % NREQ;
            end
        end else if (rq != '0) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                idx = (m_ptr + k) % NREQ;
                if (rq[idx]) m_w = idx;
            end
            m_busy  = 1'b1;
            m_burst = 1;
            e.n = n; e.w = m_w; e.err = (int'(a_drv[m_w]) >= NREGS);
            exp_q.push_back(e);
        end
    endtask

    // Drive one cycle of inputs (called just after a falling edge).
    task automatic step(input bit r, input logic [NREQ-1:0] rq, input logic [NREQ-1:0] lk);
        res  = r;
        req  = rq;
        lock = lk;
        for (int i = 0; i < NREQ; i++) begin
            waddr[i*AW +: AW]       = a_drv[i];
            wdata[i*WIDTH +: WIDTH] = d_drv[i];
        end
        model_edge(edge_cnt + 1, r, rq, lk);
        @(negedge clk);
    endtask

    // Compare the grant sequence seen on gnt with a fixed expected order.
    task automatic check_log(input string name, input int exp_l[$]);
        string got_s;
        string exp_s;
        bit    ok;
        got_s = "";
        exp_s = "";
        ok    = (gnt_log.size() == exp_l.size());
        foreach (gnt_log[i]) got_s = {got_s, $sformatf("%0d ", gnt_log[i])};
        foreach (exp_l[i]) begin
            exp_s = {exp_s, $sformatf("%0d ", exp_l[i])};
            if (ok && gnt_log[i] != exp_l[i]) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL order %s got %s want %s", name, got_s, exp_s);
        end
    endtask

    task automatic clear_drv();
        for (int i = 0; i < NREQ; i++) begin
            a_drv[i]  = '0;
            d_drv[i]  = '0;
            m_done[i] = 1'b0;
            pend[i]   = 1'b0;
        end
    endtask

    initial begin
        logic [NREQ-1:0] rq;
        logic [NREQ-1:0] lk;
        bit              r;
        for (int k = 0; k < NREGS; k++) m_bank[k] = '0;
        clear_drv();
        @(negedge clk);
        mon_en = 1'b1;
        step(1'b1, '0, '0);
        step(1'b1, '0, '0);

        // Single write: requester 0 puts A5 into register 2.
        a_drv[0] = 3'd2; d_drv[0] = 8'hA5;
        gnt_log.delete();
        step(1'b0, 4'b0001, '0);
        step(1'b0, 4'b0001, '0);
        step(1'b0, 4'b0000, '0);
        step(1'b0, 4'b0000, '0);
        check_log("single", '{0});

        // All requesters held high: grants rotate from requester 0.
        step(1'b1, '0, '0);
        clear_drv();
        for (int i = 0; i < NREQ; i++) begin
            a_drv[i] = AW'(i);
            d_drv[i] = WIDTH'(8'h10 + i);
        end
        gnt_log.delete();
        for (int c = 0; c < 10; c++) step(1'b0, 4'b1111, '0);
        step(1'b0, 4'b0000, '0);
        check_log("rotate", '{0, 1, 2, 3, 0});

        // Requester 3 first, then 0 and 2 together: 0 wins, then 2.
        step(1'b1, '0, '0);
        clear_drv();
        a_drv[3] = 3'd4; d_drv[3] = 8'h33;
        a_drv[0] = 3'd0; d_drv[0] = 8'h44;
        a_drv[2] = 3'd1; d_drv[2] = 8'h55;
        gnt_log.delete();
        step(1'b0, 4'b1000, '0);
        step(1'b0, 4'b1000, '0);
        step(1'b0, 4'b0101, '0);
        step(1'b0, 4'b0101, '0);
        step(1'b0, 4'b0100, '0);
        step(1'b0, 4'b0100, '0);
        step(1'b0, 4'b0000, '0);
        check_log("wrap", '{3, 0, 2});

        // Reset at the edge that would complete a write of FF.
        step(1'b1, '0, '0);
        clear_drv();
        a_drv[0] = 3'd1; d_drv[0] = 8'hFF;
        gnt_log.delete();
        step(1'b0, 4'b0001, '0);
        step(1'b1, 4'b0001, '0);
        step(1'b0, 4'b0000, '0);
        step(1'b0, 4'b0000, '0);
        check_log("reset_mid", '{0});

        // Out-of-range address: grant and err together, bank untouched.
        a_drv[1] = 3'd6; d_drv[1] = 8'h77;
        gnt_log.delete();
        step(1'b0, 4'b0010, '0);
        step(1'b0, 4'b0010, '0);
        step(1'b0, 4'b0000, '0);
        step(1'b0, 4'b0000, '0);
        check_log("oob", '{1});

        // Locked burst by requester 1 while requester 0 also waits.
        step(1'b1, '0, '0);
        clear_drv();
        a_drv[0] = 3'd0; d_drv[0] = 8'h60;
        step(1'b0, 4'b0001, '0);
        step(1'b0, 4'b0001, '0);
        a_drv[1] = 3'd3; d_drv[1] = 8'h71;
        gnt_log.delete();
        for (int c = 0; c < 10; c++) step(1'b0, 4'b0011, 4'b0010);
        step(1'b0, 4'b0001, '0);
        step(1'b0, 4'b0000, '0);
        step(1'b0, 4'b0000, '0);
`ifdef REGBANK_LOCK_EN
        check_log("lock", '{1, 1, 1, 1, 1, 1, 1, 1, 0});
`else
        check_log("nolock", '{1, 0, 1, 0, 1, 0});
`endif

        // Random traffic from contract-abiding requesters.
        step(1'b1, '0, '0);
        clear_drv();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (m_done[i]) begin
                    pend[i]   = 1'b0;
                    m_done[i] = 1'b0;
                end
                if (!pend[i] && $urandom_range(3) == 0) begin
                    pend[i]  = 1'b1;
                    a_drv[i] = AW'($urandom_range(7));
                    d_drv[i] = WIDTH'($urandom);
                end
                rq[i] = pend[i];
                lk[i] = ($urandom_range(1) == 1);
            end
            r = ($urandom_range(99) == 0);
            step(r, rq, lk);
        end
        for (int c = 0; c < 12; c++) step(1'b0, '0, '0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending grants want 0", exp_q.size());
        end
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regbank_wr_arbiter.md
# regbank_wr_arbiter

Owns a bank of `NREGS` registers, each `WIDTH` bits wide, built from the team's synchronous-reset flip-flop cells. It shares the bank's single write port among `NREQ` requesters using a round-robin arbiter and a two-state FSM. All register contents are exposed continuously on a flat read bus. It sits between the datapath's register storage and the units that update it, such as the ALU writeback, the loader and the debug port.

## Interface
Parameters:
- `NREQ`, default 4: number of write requesters, 2..8.
- `NREGS`, default 4: number of registers in the bank, 2..16.
- `WIDTH`, default 8: register width in bits.
- `AW`, default `$clog2(NREGS)`, minimum 1: address width.

Ports:
- `clk`, input, 1: the only clock; everything updates on its rising edge.
- `res`, input, 1: synchronous reset, active-high.
- `req`, input, `NREQ`: level request per requester.
- `waddr`, input, `NREQ*AW`: target address; slice i belongs to requester i.
- `wdata`, input, `NREQ*WIDTH`: write data; slice i belongs to requester i.
- `lock`, input, `NREQ`: burst-hold request (see Configuration).
- `gnt`, output, `NREQ`: one-hot grant; also serves as the write acknowledge.
- `err`, output, 1: the granted write was dropped because its address was ≥ `NREGS`.
- `busy`, output, 1: FSM is in WRITE.
- `q`, output, `NREGS*WIDTH`: register contents; slice k is register k.

## Operation
- FSM states:
  - IDLE: no grant.
  - WRITE: exactly one requester, the winner `w`, holds `gnt[w]`.
- IDLE → WRITE when any `req` bit is high at the edge:
  - The winner is the first set `req` bit, searching from pointer `ptr` upward and wrapping modulo `NREQ`.
  - `w` is latched.
  - `waddr` and `wdata` are not latched; they are sampled live from slice `w` during WRITE.
- IDLE → IDLE when `req` = 0.
- WRITE actions:
  - `gnt[w]` = 1 and `busy` = 1.
  - At the edge ending the cycle, register `waddr[w]` is loaded with `wdata[w]`, provided that address < `NREGS`.
  - If the address is ≥ `NREGS`, no register changes and `err` = 1 for that cycle.
- WRITE → IDLE at the edge ending the cycle, and `ptr` ← (w+1) mod `NREQ`. The only exception is the lock hold under Configuration.
- Requester contract:
  - Hold `req`, `waddr` and `wdata` stable from assertion through the `gnt` cycle.
  - Drop `req` after the edge ending the `gnt` cycle if no further write is wanted.
  - A `req` still high when the FSM is back in IDLE is arbitrated as a new request.
- `gnt`, `err` and `busy` are derived only from state registers; they have no combinational path from `req`.
- Non-granted requesters see no effect and simply wait; there is no timeout.
- Fairness: with every `req` held high, grants rotate 0,1,…,`NREQ`−1,0,…

## Timing
- Reset values, taken at any edge with `res` = 1:
  - state = IDLE, `ptr` = 0, `w` = 0.
  - `gnt` = 0, `err` = 0, `busy` = 0.
  - All registers = 0, so `q` = 0.
- `req` sampled high at edge E0 gives:
  - `gnt[w]` high between E0 and E1.
  - Register written at E1.
  - New value visible on `q` after E1.
- Request-to-visible latency is 2 edges; sustained throughput is 1 write per 2 cycles (unlocked).
- Reset mid-operation:
  - If `res` = 1 at the edge ending a WRITE cycle, the write is discarded.
  - The bank is cleared to 0 and the FSM goes to IDLE.
  - The requester saw `gnt` but must re-issue; `res` takes priority over the write.
- Simultaneous requests in the same edge are resolved by the round-robin order only; no requester has fixed priority.
- Pointer wrap: granting requester `NREQ`−1 sets `ptr` = 0.

## Configuration
- Macro `REGBANK_LOCK_EN`.
- When defined:
  - In WRITE, if `lock[w]` and `req[w]` are both high at the edge, the FSM stays in WRITE with the same `w`, and `ptr` is not advanced.
  - The next cycle performs another write using the current `waddr[w]`/`wdata[w]` (one write per cycle).
  - The burst is capped at 8 consecutive WRITE cycles; the 8th cycle always exits to IDLE and advances `ptr`.
- When undefined:
  - The `lock` port exists but is ignored.
  - Behaviour is exactly as in Operation.

## Test plan
- Reset, then a single write: `req` = 0001, `waddr0` = 2, `wdata0` = 8'hA5.
  - `gnt` = 0001 for 1 cycle.
  - `q` register 2 = A5 two edges after the request; every other register stays 0.
- All `req` held at 1111, each requester i writing 8'h10+i to address i.
  - Grant order is 0,1,2,3,0.
  - After the first rotation, `q` = {13,12,11,10}.
- Request from requester 3, then a simultaneous request from 0 and 2 once `ptr` = 0 after that grant.
  - Grant goes to 0, then 2.
- `res` asserted during a WRITE cycle carrying 8'hFF.
  - The register reads 0 afterwards.
  - `gnt`, `busy` and `err` are 0 the next cycle.
- `NREGS` = 3 with `waddr` = 3: `gnt` and `err` pulse together and no register changes.
- With `REGBANK_LOCK_EN`, requester 1 holds `req` and `lock` high for 10 cycles while requester 0 also requests.
  - Requester 1 gets 8 consecutive grants.
  - Requester 0 is granted next.
